// File: rtl/render_clear_bounce_if.sv
// rtl/render_clear_bounce_if.sv - draw-interface bundle for render_clear_bounce
//
// Purpose: groups frame control and pixel output of the render engine.
// Ports (signals):
//   oe, start              : controller -> engine (output enable, frame start)
//   x, y, cidx, drawing    : engine -> framebuffer pixel stream
//   busy, done             : engine status
// Modports: master = render engine, slave = controller / pixel consumer.
interface render_clear_bounce_if #(
  parameter int CORDW = 16,
  parameter int CIDXW = 4
);
  logic                    oe;
  logic                    start;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic [CIDXW-1:0]        cidx;
  logic                    drawing;
  logic                    busy;
  logic                    done;

  modport master (
    input  oe, start,
    output x, y, cidx, drawing, busy, done
  );

  modport slave (
    output oe, start,
    input  x, y, cidx, drawing, busy, done
  );
endinterface

// File: rtl/render_clear_bounce.sv
// rtl/render_clear_bounce.sv - framebuffer clear plus bouncing filled square renderer
//
// Purpose: on each accepted start, raster-clears the framebuffer to BG_CIDX,
// steps a bouncing square one move, then raster-fills the square with a
// cycling colour index. One pixel per cycle while drawing.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : render_clear_bounce_if.master (oe/start in; x/y/cidx/drawing/busy/done out)
module render_clear_bounce #(
  parameter int CORDW     = 16,
  parameter int CIDXW     = 4,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180,
  parameter int Q_SIZE    = 32,
  parameter int SPEED     = 1,
  parameter int BG_CIDX   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  render_clear_bounce_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef logic signed [CORDW-1:0] coord_t;
  typedef logic [CIDXW-1:0]        cidx_t;

  localparam coord_t C_ZERO = coord_t'(0);
  localparam coord_t C_ONE  = coord_t'(1);
  localparam coord_t W_LAST = coord_t'(FB_WIDTH - 1);
  localparam coord_t H_LAST = coord_t'(FB_HEIGHT - 1);
  localparam coord_t FB_W   = coord_t'(FB_WIDTH);
  localparam coord_t FB_H   = coord_t'(FB_HEIGHT);
  localparam coord_t Q_SZ   = coord_t'(Q_SIZE);
  localparam coord_t Q_LAST = coord_t'(Q_SIZE - 1);
  localparam coord_t STEP   = coord_t'(SPEED);
  localparam cidx_t  BG     = cidx_t'(BG_CIDX);
  localparam cidx_t  SQ_INIT = cidx_t'(BG_CIDX + 1);
  localparam cidx_t  CIDX_ONE = cidx_t'(1);

  logic [2:0] state_q, state_d;
  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  cidx_t      cidx_q, cidx_d;
  coord_t     qx_q, qx_d;
  coord_t     qy_q, qy_d;
  logic       dx_neg_q, dx_neg_d;  // 1 = moving towards 0
  logic       dy_neg_q, dy_neg_d;
  cidx_t      sq_cidx_q, sq_cidx_d;

  logic         drawing;
  logic [CORDW:0] x_step;
  logic [CORDW:0] y_step;
  cidx_t        sq_next;

  // One bounce step on one axis; returns {new_dir_neg, new_pos}.
  // Overshooting the far edge clamps flush against it, overshooting 0 clamps to 0.
  function automatic logic [CORDW:0] step_axis(input coord_t pos, input logic neg,
                                               input coord_t limit);
    if (!neg) begin
      if (pos + Q_SZ + STEP > limit) return {1'b1, coord_t'(limit - Q_SZ)};
      else                           return {1'b0, coord_t'(pos + STEP)};
    end else begin
      if (pos < STEP) return {1'b0, C_ZERO};
      else            return {1'b1, coord_t'(pos - STEP)};
    end
  endfunction

  assign x_step  = step_axis(qx_q, dx_neg_q, FB_W);
  assign y_step  = step_axis(qy_q, dy_neg_q, FB_H);
  assign drawing = ((state_q == S_CLEAR) || (state_q == S_DRAW)) && bus.oe;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cidx_d    = cidx_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;
    sq_cidx_d = sq_cidx_q;
    sq_next   = sq_cidx_q + CIDX_ONE;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          x_d     = C_ZERO;
          y_d     = C_ZERO;
          cidx_d  = BG;
        end
      end

      S_CLEAR: begin
        if (drawing) begin
          if (x_q == W_LAST) begin
            x_d = C_ZERO;
            if (y_q == H_LAST) state_d = S_MOVE;
            else               y_d = y_q + C_ONE;
          end else begin
            x_d = x_q + C_ONE;
          end
        end
      end

      // Ignores oe: no pixel is presented here.
      S_MOVE: begin
        {dx_neg_d, qx_d} = x_step;
        {dy_neg_d, qy_d} = y_step;
        x_d     = x_step[CORDW-1:0];
        y_d     = y_step[CORDW-1:0];
        cidx_d  = sq_cidx_q;
        state_d = S_DRAW;
      end

      S_DRAW: begin
        if (drawing) begin
          if (x_q == qx_q + Q_LAST) begin
            x_d = qx_q;
            if (y_q == qy_q + Q_LAST) state_d = S_DONE;
            else                      y_d = y_q + C_ONE;
          end else begin
            x_d = x_q + C_ONE;
          end
        end
      end

      // Square colour skips the background index so it stays visible.
      S_DONE: begin
        if (sq_next == BG) sq_cidx_d = sq_next + CIDX_ONE;
        else               sq_cidx_d = sq_next;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= C_ZERO;
      y_q       <= C_ZERO;
      cidx_q    <= BG;
      qx_q      <= C_ZERO;
      qy_q      <= C_ZERO;
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b0;
      sq_cidx_q <= SQ_INIT;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cidx_q    <= cidx_d;
      qx_q      <= qx_d;
      qy_q      <= qy_d;
      dx_neg_q  <= dx_neg_d;
      dy_neg_q  <= dy_neg_d;
      sq_cidx_q <= sq_cidx_d;
    end
  end

  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.cidx    = cidx_q;
  assign bus.drawing = drawing;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_render_clear_bounce.sv
// tb/tb_render_clear_bounce.sv - randomized self-checking bench for render_clear_bounce
module tb_render_clear_bounce;

  localparam int TW     = 20;
  localparam int TH     = 12;
  localparam int TQ     = 4;
  localparam int TS     = 3;
  localparam int TBG    = 3;
  localparam int BUDGET = 4 * (TW * TH + TQ * TQ) + 50;

  logic clk = 1'b0;
  logic rst_n;
  logic oe;
  logic start;

  render_clear_bounce_if #(.CORDW(16), .CIDXW(4)) bus ();

  render_clear_bounce #(
    .CORDW(16), .CIDXW(4), .FB_WIDTH(TW), .FB_HEIGHT(TH),
    .Q_SIZE(TQ), .SPEED(TS), .BG_CIDX(TBG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.oe    = oe;
  assign bus.start = start;

  logic signed [15:0] x, y;
  logic [3:0]         cidx;
  logic               drawing, busy, done;
  assign x       = bus.x;
  assign y       = bus.y;
  assign cidx    = bus.cidx;
  assign drawing = bus.drawing;
  assign busy    = bus.busy;
  assign done    = bus.done;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [35:0] got_q[$];
  logic [35:0] exp_q[$];

  // reference model state: square origin, direction, next square colour
  int mqx, mqy, mdx, mdy, mcol;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pk(input int px, input int py, input int pc);
    return {16'(px), 16'(py), 4'(pc)};
  endfunction

  task automatic model_reset();
    mqx = 0; mqy = 0; mdx = 1; mdy = 1; mcol = (TBG + 1) % 16;
  endtask

  task automatic bounce(inout int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + TQ + TS > lim) begin p = lim - TQ; d = -1; end
      else p = p + TS;
    end else begin
      if (p < TS) begin p = 0; d = 1; end
      else p = p - TS;
    end
  endtask

  task automatic model_frame();
    for (int yy = 0; yy < TH; yy++)
      for (int xx = 0; xx < TW; xx++)
        exp_q.push_back(pk(xx, yy, TBG));
    bounce(mqx, mdx, TW);
    bounce(mqy, mdy, TH);
    for (int yy = 0; yy < TQ; yy++)
      for (int xx = 0; xx < TQ; xx++)
        exp_q.push_back(pk(mqx + xx, mqy + yy, mcol));
    mcol = (mcol + 1) % 16;
    if (mcol == TBG) mcol = (mcol + 1) % 16;
  endtask

  always @(negedge clk)
    if (rst_n && drawing) got_q.push_back({x, y, cidx});

  task automatic compare_pixels();
    int n;
    check("pix_count", 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("pixel", got_q[i], exp_q[i]);
  endtask

  task automatic run_frame(input bit rand_oe, input bit poke, input int rst_at);
    int k, dones;
    bit hv, can_hold;
    logic signed [15:0] sx, sy;
    logic [3:0] sc;
    exp_q.delete();
    got_q.delete();
    model_frame();
    @(posedge clk); #1; start = 1'b1; oe = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
    check("first_pixel", {drawing, x, y, cidx}, {1'b1, 16'd0, 16'd0, 4'(TBG)});
    k = 0; dones = 0; hv = 1'b0; sx = '0; sy = '0; sc = '0;
    while (dones == 0 && k < BUDGET) begin
      if (hv) begin
        check("hold_xyc", {x, y, cidx}, {sx, sy, sc});
        check("hold_nodraw", 64'(drawing), 64'd0);
      end
      if (rand_oe) begin
        can_hold = hv || (oe && drawing);
        oe = ($urandom_range(0, 2) != 0);
        hv = can_hold && !oe;
        if (hv) begin sx = x; sy = y; sc = cidx; end
      end
      if (poke) start = ($urandom_range(0, 7) == 0);
      if (rst_at != 0 && k == rst_at) rst_n = 1'b0;
      @(posedge clk); #1; k++;
      start = 1'b0;
      if (!rst_n) begin
        check("rst_x", 64'(x), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_cidx", 64'(cidx), 64'(TBG));
        check("rst_flags", {drawing, busy, done}, 3'b000);
        rst_n = 1'b1;
        dones = 0;
        repeat (TW * TH + TQ * TQ + 4) begin
          @(posedge clk); #1;
          if (done) dones++;
        end
        check("rst_no_done", 64'(dones), 64'd0);
        check("rst_idle", 64'(busy), 64'd0);
        model_reset();
        got_q.delete();
        return;
      end
      if (!rand_oe && k == TW * TH) begin
        check("move_nodraw", 64'(drawing), 64'd0);
        check("move_busy", 64'(busy), 64'd1);
      end
      if (done) dones++;
    end
    oe = 1'b1;
    check("frame_done", 64'(dones), 64'd1);
    if (!rand_oe) check("done_latency", 64'(k), 64'(TW * TH + TQ * TQ + 1));
    check("done_busy", 64'(busy), 64'd1);
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check("done_start_ignored", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check("still_idle", 64'(busy), 64'd0);
    end else begin
      @(posedge clk); #1;
      check("idle_after_done", {busy, done}, 2'b00);
    end
    compare_pixels();
  endtask

  task automatic run_held();
    int k, dones;
    exp_q.delete();
    got_q.delete();
    model_frame();
    model_frame();
    oe = 1'b1;
    @(posedge clk); #1; start = 1'b1;
    k = 0; dones = 0;
    while (dones < 2 && k < 2 * BUDGET) begin
      @(posedge clk); #1; k++;
      if (done) begin
        dones++;
        if (dones == 1) begin
          @(posedge clk); #1; k++;
          check("held_idle", 64'(busy), 64'd0);
          @(posedge clk); #1; k++;
          check("held_restart", {drawing, x, y}, {1'b1, 16'd0, 16'd0});
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("held_dones", 64'(dones), 64'd2);
    @(posedge clk); #1;
    check("held_end_idle", 64'(busy), 64'd0);
    compare_pixels();
  endtask

  initial begin
    rst_n = 1'b0; oe = 1'b0; start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", 64'(x), 64'd0);
    check("reset_y", 64'(y), 64'd0);
    check("reset_cidx", 64'(cidx), 64'(TBG));
    check("reset_flags", {drawing, busy, done}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start", 64'(busy), 64'd0);

    run_frame(1'b0, 1'b0, 0);
    run_frame(1'b0, 1'b1, 0);
    for (int f = 0; f < 6; f++) run_frame(1'b1, 1'($urandom_range(0, 1)), 0);

    run_frame(1'b0, 1'b0, TW * TH + 8);
    run_frame(1'b0, 1'b0, 0);
    if (got_q.size() > TW * TH)
      check("post_rst_square", got_q[TW * TH], pk(TS, TS, TBG + 1));
    else
      check("post_rst_square_missing", 64'(got_q.size()), 64'(TW * TH + 1));

    for (int f = 0; f < 16; f++)
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    run_held();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
